time_set_ctrl: RTL

TIME_SET_CTRL -- requirements
Module: time_set_ctrl

---
 rtl/time_set_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/time_set_ctrl.sv
// Time-of-day edit controller: key-driven field editing with blink and idle timeout.
// Edits a private copy of the live time and strobes load when the edit is committed.
module time_set_ctrl #(
   parameter int BLINK_HALF   = 25_000_000,
   parameter int IDLE_TIMEOUT = 500_000_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        key_mode,
   input  logic        key_inc,
   input  logic        key_dec,
   input  logic [16:0] time_in,
   output logic        load,
   output logic [16:0] time_set,
   output logic [1:0]  edit_state,
   output logic [5:0]  blink_mask
);

   localparam int BW = $clog2(BLINK_HALF + 1);
   localparam int IW = $clog2(IDLE_TIMEOUT + 1);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      SET_H = 2'd1,
      SET_M = 2'd2,
      SET_S = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [16:0]   tset_q, tset_d;
   logic          load_q, load_d;
   logic [IW-1:0] idle_q, idle_d;
   logic [BW-1:0] blink_q, blink_d;
   logic          phase_q, phase_d;
   logic [5:0]    mask_q, mask_d;

   logic in_edit;
   logic any_key;
   logic step_ok;
   logic timeout;

   // Modular +/-1 over 0..max.
   function automatic logic [5:0] wrap_step(
      input logic [5:0] v,
      input logic [5:0] max,
      input logic       up
   );
      if (up) return (v == max) ? 6'd0 : v + 6'd1;
      else    return (v == 6'd0) ? max : v - 6'd1;
   endfunction

   always_comb begin
      state_d = state_q;
      tset_d  = tset_q;
      load_d  = 1'b0;
      idle_d  = idle_q;
      blink_d = blink_q;
      phase_d = phase_q;
      mask_d  = 6'b0;

      in_edit = (state_q != RUN);
      any_key = key_mode | key_inc | key_dec;
      step_ok = in_edit && !key_mode && (key_inc ^ key_dec);
      timeout = in_edit && !any_key
                && (idle_q == IW'(IDLE_TIMEOUT - 1));

      unique case (1'b1)
         key_mode: begin
            unique case (state_q)
               RUN: begin
                  state_d = SET_H;
                  tset_d  = time_in;
               end
               SET_H: state_d = SET_M;
               SET_M: state_d = SET_S;
               SET_S: begin
                  state_d = RUN;
                  load_d  = 1'b1;
               end
               default: state_d = RUN;
            endcase
         end
         step_ok: begin
            unique case (state_q)
               SET_H: tset_d[16:12] = 5'(wrap_step(
                         {1'b0, tset_q[16:12]}, 6'd23, key_inc));
               SET_M: tset_d[11:6] = wrap_step(
                         tset_q[11:6], 6'd59, key_inc);
               SET_S: tset_d[5:0] = wrap_step(
                         tset_q[5:0], 6'd59, key_inc);
               default: tset_d = tset_q;
            endcase
         end
         timeout: state_d = RUN;
         default: state_d = state_q;
      endcase

      if (!in_edit || any_key || timeout) begin
         idle_d = '0;
      end else begin
         idle_d = idle_q + IW'(1);
      end

      // Restart the blink on any visible change so the field shows at once.
      if (state_d != state_q || step_ok || state_d == RUN) begin
         blink_d = '0;
         phase_d = 1'b0;
      end else if (blink_q == BW'(BLINK_HALF - 1)) begin
         blink_d = '0;
         phase_d = ~phase_q;
      end else begin
         blink_d = blink_q + BW'(1);
      end

      if (phase_d) begin
         unique case (state_d)
            SET_H:   mask_d = 6'b110000;
            SET_M:   mask_d = 6'b001100;
            SET_S:   mask_d = 6'b000011;
            default: mask_d = 6'b000000;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
         tset_q  <= '0;
         load_q  <= 1'b0;
         idle_q  <= '0;
         blink_q <= '0;
         phase_q <= 1'b0;
         mask_q  <= '0;
      end else begin
         state_q <= state_d;
         tset_q  <= tset_d;
         load_q  <= load_d;
         idle_q  <= idle_d;
         blink_q <= blink_d;
         phase_q <= phase_d;
         mask_q  <= mask_d;
      end
   end

   assign load       = load_q;
   assign time_set   = tset_q;
   assign edit_state = state_q;
   assign blink_mask = mask_q;

endmodule
